// File: rtl/sram_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_bus_arbiter_if
//   Requester-side handshake bundle for the SRAM bus arbiter.
//   master : the requester block (VGA reader, CPU data port, CPU fetch)
//   slave  : the arbiter
//   Signals
//     vga_req/vga_addr                   VGA read request, held until vga_ack
//     dat_req/dat_we/dat_addr/dat_wdata  CPU data request, held until dat_ack
//     if_req/if_addr                     fetch request, held until if_ack
//     vga_ack/dat_ack/if_ack             one-cycle completion pulses
//     rdata                              last read data, valid from its ack
//     busy                               arbiter not idle
// ---------------------------------------------------------------------------
interface sram_bus_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              dat_req;
  logic              dat_we;
  logic [ADDR_W-1:0] dat_addr;
  logic [DATA_W-1:0] dat_wdata;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              vga_ack;
  logic              dat_ack;
  logic              if_ack;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport master (
    output vga_req, vga_addr, dat_req, dat_we, dat_addr, dat_wdata, if_req, if_addr,
    input  vga_ack, dat_ack, if_ack, rdata, busy
  );

  modport slave (
    input  vga_req, vga_addr, dat_req, dat_we, dat_addr, dat_wdata, if_req, if_addr,
    output vga_ack, dat_ack, if_ack, rdata, busy
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// ---------------------------------------------------------------------------
// sram_bus_arbiter
//   Shares one asynchronous 16-bit SRAM between the VGA scan-out reader, the
//   CPU data port and the CPU instruction fetch. Each access runs
//   IDLE -> ADDR -> ACCESS (WAIT_CYCLES) -> FINISH, and FINISH can chain
//   straight into the next ADDR. Priority VGA > data > fetch, except that
//   fetch is forced through after STARVE_MAX consecutive losses.
//   Ports
//     clk, rst    rising-edge clock, asynchronous active-high reset
//     arb         requester handshake bundle (slave side)
//     memAddrBus  SRAM word address
//     memDataBus  SRAM data, driven only while a write is in flight
//     memRead     OE_n, memWrite WE_n, memEnable CE_n (all active low)
//   All SRAM-facing outputs and acks come straight from flops.
// ---------------------------------------------------------------------------
module sram_bus_arbiter #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1,
  parameter int STARVE_MAX  = 4
) (
  input  logic              clk,
  input  logic              rst,
  sram_bus_arbiter_if.slave arb,
  output logic [ADDR_W-1:0] memAddrBus,
  inout  wire  [DATA_W-1:0] memDataBus,
  output logic              memRead,
  output logic              memWrite,
  output logic              memEnable
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_VGA  = 2'd1;
  localparam logic [1:0] GNT_DAT  = 2'd2;
  localparam logic [1:0] GNT_IF   = 2'd3;

  localparam logic [2:0] WAIT_LAST  = 3'(WAIT_CYCLES - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e            state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        wait_q, wait_d;
  logic [3:0]        starve_q, starve_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [2:0]        ack_q, ack_d;      // {vga, dat, if}
  logic              busy_q, busy_d;
  logic              en_n_q, en_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              drv_q, drv_d;
  logic [1:0]        win_s;

  // Fixed priority with a starvation override; 'excl' masks the requester
  // that is being acked this cycle so it cannot immediately win again.
  function automatic logic [1:0] arbitrate(
    input logic       vga,
    input logic       dat,
    input logic       fetch,
    input logic [1:0] excl,
    input logic [3:0] starve
  );
    logic       v, d, f;
    logic [1:0] res;
    v = vga   && (excl != GNT_VGA);
    d = dat   && (excl != GNT_DAT);
    f = fetch && (excl != GNT_IF);
    if (f && (starve == STARVE_LIM)) begin
      res = GNT_IF;
    end else if (v) begin
      res = GNT_VGA;
    end else if (d) begin
      res = GNT_DAT;
    end else if (f) begin
      res = GNT_IF;
    end else begin
      res = GNT_NONE;
    end
    return res;
  endfunction

  // State register: FSM state, captured grant, counters and output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= GNT_NONE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wait_q   <= 3'd0;
      starve_q <= 4'd0;
      rdata_q  <= '0;
      ack_q    <= 3'b000;
      busy_q   <= 1'b0;
      en_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      drv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      wait_q   <= wait_d;
      starve_q <= starve_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      en_n_q   <= en_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      drv_q    <= drv_d;
    end
  end

  // Next-state logic: arbitration, grant capture, strobe timing, read sampling.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    wait_d   = wait_q;
    starve_d = starve_q;
    rdata_d  = rdata_q;

    case (state_q)
      ST_IDLE:   win_s = arbitrate(arb.vga_req, arb.dat_req, arb.if_req, GNT_NONE, starve_q);
      ST_FINISH: win_s = arbitrate(arb.vga_req, arb.dat_req, arb.if_req, gnt_q, starve_q);
      default:   win_s = GNT_NONE;
    endcase

    case (state_q)
      ST_IDLE, ST_FINISH: begin
        if (win_s != GNT_NONE) begin
          state_d = ST_ADDR;
          gnt_d   = win_s;
          case (win_s)
            GNT_VGA: begin
              addr_d = arb.vga_addr;
              we_d   = 1'b0;
            end
            GNT_DAT: begin
              addr_d  = arb.dat_addr;
              we_d    = arb.dat_we;
              wdata_d = arb.dat_wdata;
            end
            GNT_IF: begin
              addr_d = arb.if_addr;
              we_d   = 1'b0;
            end
            default: begin
              addr_d = addr_q;
              we_d   = we_q;
            end
          endcase
          // Fetch losing a grant while asking counts toward the override.
          if (win_s == GNT_IF) begin
            starve_d = 4'd0;
          end else if (arb.if_req && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 4'd1;
          end else begin
            starve_d = starve_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        state_d = ST_ACCESS;
        wait_d  = WAIT_LAST;
      end
      ST_ACCESS: begin
        if (wait_q == 3'd0) begin
          state_d = ST_FINISH;
          if (!we_q) begin
            rdata_d = memDataBus;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every SRAM pin and ack is a flop.
  always_comb begin
    en_n_d = 1'b1;
    oe_n_d = 1'b1;
    we_n_d = 1'b1;
    drv_d  = 1'b0;
    ack_d  = 3'b000;
    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_ADDR: begin
        en_n_d = 1'b0;
        drv_d  = we_d;
      end
      ST_ACCESS: begin
        en_n_d = 1'b0;
        oe_n_d = we_d;
        we_n_d = !we_d;
        drv_d  = we_d;
      end
      ST_FINISH: begin
        en_n_d = 1'b0;
        drv_d  = we_d;   // keep write data on the bus for hold time
        case (gnt_d)
          GNT_VGA: ack_d = 3'b100;
          GNT_DAT: ack_d = 3'b010;
          GNT_IF:  ack_d = 3'b001;
          default: ack_d = 3'b000;
        endcase
      end
      default: begin
        en_n_d = 1'b1;
      end
    endcase
  end

  assign memAddrBus  = addr_q;
  assign memEnable   = en_n_q;
  assign memRead     = oe_n_q;
  assign memWrite    = we_n_q;
  assign memDataBus  = drv_q ? wdata_q : {DATA_W{1'bz}};
  assign arb.vga_ack = ack_q[2];
  assign arb.dat_ack = ack_q[1];
  assign arb.if_ack  = ack_q[0];
  assign arb.rdata   = rdata_q;
  assign arb.busy    = busy_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_bus_arbiter
//   Directed bench for sram_bus_arbiter. Expected transactions (who, we,
//   address, write data, read data) are queued in service order before the
//   requests are raised; a negedge monitor pops one entry per ack and also
//   checks address/strobe/data of the access in flight against the queue head.
//   A second instance with WAIT_CYCLES=3 covers the long-strobe read.
// ---------------------------------------------------------------------------
module tb_sram_bus_arbiter;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam logic [1:0] W_VGA = 2'd1;
  localparam logic [1:0] W_DAT = 2'd2;
  localparam logic [1:0] W_IF  = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a0 ();
  sram_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a3 ();

  wire  [DW-1:0] md0, md3;
  logic [AW-1:0] ma0, ma3;
  logic oe0, we0, ce0, oe3, we3, ce3;

  sram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1), .STARVE_MAX(4)) u_dut (
    .clk(clk), .rst(rst), .arb(a0.slave),
    .memAddrBus(ma0), .memDataBus(md0), .memRead(oe0), .memWrite(we0), .memEnable(ce0)
  );

  sram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .rst(rst), .arb(a3.slave),
    .memAddrBus(ma3), .memDataBus(md3), .memRead(oe3), .memWrite(we3), .memEnable(ce3)
  );

  // SRAM model: unwritten words read back as addr[15:0] ^ 16'h5A5A.
  bit   [15:0] mem_arr [256];
  bit          mem_wr  [256];
  logic [7:0]  idx0;
  logic [15:0] mrd0;
  always_comb begin
    idx0 = ma0[11:4];
    mrd0 = mem_wr[idx0] ? mem_arr[idx0] : (ma0[15:0] ^ 16'h5A5A);
  end
  assign md0 = (!oe0 && !ce0) ? mrd0 : 16'hzzzz;
  assign md3 = (!oe3 && !ce3) ? (ma3[15:0] ^ 16'h5A5A) : 16'hzzzz;

  always @(posedge clk) begin
    if (!we0 && !ce0) begin
      mem_arr[ma0[11:4]] <= md0;
      mem_wr[ma0[11:4]]  <= 1'b1;
    end
  end

  typedef struct {
    logic [1:0]  who;
    logic        we;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [15:0] rexp;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] who, input logic we, input logic [17:0] addr,
                      input logic [15:0] wd, input logic [15:0] re);
    exp_q.push_back('{who, we, addr, wd, re});
  endtask

  // Raise the requested sources, hold each until it has seen its ack count.
  task automatic run(input int nv, input int nd, input int ni, input int first_exp, input int gap_exp);
    int rv, rd, ri, cyc, last;
    rv = nv; rd = nd; ri = ni; cyc = 0; last = -1;
    @(posedge clk); #1;
    a0.vga_req = (rv > 0);
    a0.dat_req = (rd > 0);
    a0.if_req  = (ri > 0);
    while ((rv + rd + ri) > 0 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (a0.vga_ack || a0.dat_ack || a0.if_ack) begin
        if (last < 0) check("first ack latency", cyc, first_exp);
        else if (gap_exp > 0) check("ack spacing", cyc - last, gap_exp);
        last = cyc;
      end
      if (a0.vga_ack && rv > 0) begin rv--; if (rv == 0) a0.vga_req = 1'b0; end
      if (a0.dat_ack && rd > 0) begin rd--; if (rd == 0) a0.dat_req = 1'b0; end
      if (a0.if_ack  && ri > 0) begin ri--; if (ri == 0) a0.if_req  = 1'b0; end
    end
    check("acks outstanding at timeout", rv + rd + ri, 0);
    a0.vga_req = 1'b0; a0.dat_req = 1'b0; a0.if_req = 1'b0;
    @(posedge clk); #1;
    check("busy after run", a0.busy, 1'b0);
  endtask

  // Monitor: bus contents of the access in flight, strobe widths, ack scoreboard.
  initial begin
    int rd_low, wr_low;
    logic [2:0]  acks;
    logic [1:0]  who;
    exp_t e;
    rd_low = 0; wr_low = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_low = 0; wr_low = 0;
      end else begin
        if (!oe0) rd_low++;
        else if (rd_low != 0) begin check("OE low width", rd_low, 1); rd_low = 0; end
        if (!we0) wr_low++;
        else if (wr_low != 0) begin check("WE low width", wr_low, 1); wr_low = 0; end

        if (!ce0) begin
          if (exp_q.size() == 0) check("access with empty scoreboard", 1, 0);
          else begin
            e = exp_q[0];
            check("memAddrBus", ma0, e.addr);
            if (e.we) begin
              check("write data on bus", md0, e.wdata);
              check("OE idle on write", oe0, 1'b1);
            end else begin
              check("WE idle on read", we0, 1'b1);
            end
          end
        end

        acks = {a0.vga_ack, a0.dat_ack, a0.if_ack};
        if (acks != 3'b000) begin
          check("ack one-hot", ($countones(acks) == 1), 1'b1);
          who = acks[2] ? W_VGA : (acks[1] ? W_DAT : W_IF);
          if (exp_q.size() == 0) check("ack with empty scoreboard", {30'd0, who}, 0);
          else begin
            e = exp_q.pop_front();
            check("ack source", {30'd0, who}, {30'd0, e.who});
            if (!e.we) check("rdata", a0.rdata, e.rexp);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cyc, lo;
    bit got;
    a0.vga_req = 1'b0; a0.vga_addr = '0; a0.dat_req = 1'b0; a0.dat_we = 1'b0;
    a0.dat_addr = '0; a0.dat_wdata = '0; a0.if_req = 1'b0; a0.if_addr = '0;
    a3.vga_req = 1'b0; a3.vga_addr = '0; a3.dat_req = 1'b0; a3.dat_we = 1'b0;
    a3.dat_addr = '0; a3.dat_wdata = '0; a3.if_req = 1'b0; a3.if_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    // Reset state
    check("reset memEnable", ce0, 1'b1);
    check("reset memRead", oe0, 1'b1);
    check("reset memWrite", we0, 1'b1);
    check("reset memAddrBus", ma0, 0);
    check("reset rdata", a0.rdata, 0);
    check("reset busy", a0.busy, 1'b0);
    check("reset acks", {a0.vga_ack, a0.dat_ack, a0.if_ack}, 0);

    // 1: single write
    a0.dat_we = 1'b1; a0.dat_addr = 18'h00100; a0.dat_wdata = 16'h1044;
    push(W_DAT, 1'b1, 18'h00100, 16'h1044, 16'h0000);
    run(0, 1, 0, 3, 0);

    // 2: read back
    a0.dat_we = 1'b0; a0.dat_addr = 18'h00100;
    push(W_DAT, 1'b0, 18'h00100, 16'h0000, 16'h1044);
    run(0, 1, 0, 3, 0);

    // 3: all three together -> VGA, data, fetch
    a0.vga_addr = 18'h00100;
    a0.dat_we = 1'b1; a0.dat_addr = 18'h00200; a0.dat_wdata = 16'hBEEF;
    a0.if_addr = 18'h00300;
    push(W_VGA, 1'b0, 18'h00100, 16'h0000, 16'h1044);
    push(W_DAT, 1'b1, 18'h00200, 16'hBEEF, 16'h0000);
    push(W_IF,  1'b0, 18'h00300, 16'h0000, 16'h595A);
    run(1, 1, 1, 3, 3);

    // 4: VGA and data alternate; fetch forced in after 4 lost grants
    a0.vga_addr = 18'h00200;
    a0.dat_we = 1'b0; a0.dat_addr = 18'h00100;
    a0.if_addr = 18'h00300;
    push(W_VGA, 1'b0, 18'h00200, 16'h0000, 16'hBEEF);
    push(W_DAT, 1'b0, 18'h00100, 16'h0000, 16'h1044);
    push(W_VGA, 1'b0, 18'h00200, 16'h0000, 16'hBEEF);
    push(W_DAT, 1'b0, 18'h00100, 16'h0000, 16'h1044);
    push(W_IF,  1'b0, 18'h00300, 16'h0000, 16'h595A);
    push(W_VGA, 1'b0, 18'h00200, 16'h0000, 16'hBEEF);
    run(3, 2, 1, 3, 3);

    // 5: reset during the strobe of a write, then the write is redone
    a0.dat_we = 1'b1; a0.dat_addr = 18'h00400; a0.dat_wdata = 16'h5555;
    push(W_DAT, 1'b1, 18'h00400, 16'h5555, 16'h0000);
    @(posedge clk); #1;
    a0.dat_req = 1'b1;
    cyc = 0;
    while (we0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("WE strobe cycle", cyc, 2);
    #2 rst = 1'b1;
    #1;
    check("rst releases WE", we0, 1'b1);
    check("rst releases CE", ce0, 1'b1);
    check("rst clears busy", a0.busy, 1'b0);
    check("rst clears rdata", a0.rdata, 0);
    check("rst no ack", a0.dat_ack, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
      if (a0.dat_ack) begin
        got = 1'b1;
        check("redo ack latency", cyc, 3);
        a0.dat_req = 1'b0;
      end
    end
    check("redo ack seen", got, 1'b1);
    a0.dat_req = 1'b0;
    @(posedge clk); #1;
    a0.dat_we = 1'b0; a0.dat_addr = 18'h00400;
    push(W_DAT, 1'b0, 18'h00400, 16'h0000, 16'h5555);
    run(0, 1, 0, 3, 0);

    // 6: WAIT_CYCLES=3 instance, single read
    @(posedge clk); #1;
    a3.dat_we = 1'b0; a3.dat_addr = 18'h00050; a3.dat_req = 1'b1;
    cyc = 0; lo = 0; got = 1'b0;
    while (!got && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
      if (!oe3) lo++;
      if (a3.dat_ack) begin
        got = 1'b1;
        check("long read ack latency", cyc, 5);
        check("long read rdata", a3.rdata, 16'h5A0A);
        a3.dat_req = 1'b0;
      end
    end
    check("long read ack seen", got, 1'b1);
    check("long read OE low cycles", lo, 3);
    a3.dat_req = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
